fpu_special_opgen: RTL and testbench
====================================

# fpu_special_opgen

Sequential stimulus source that produces IEEE-754 single-precision operand pairs (`opa`, `opb`) of chosen classes: zero, denormal, normal, infinity, quiet NaN, signalling NaN. For each pair it also produces the exception flags that the FPU `except` stage must raise two cycles later. It sits in the FPU verification environment in front of the operand registers, and drives the encode side of the operand-classification interface that `except` decodes. Payload bits come from LFSRs, so runs are reproducible from a seed.

## Interface
Parameters:
- `SEED`, default 32'hACE1_2B3D: nonzero seed for the opa LFSR. The opb LFSR is seeded with ~SEED.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request. Sampled only in IDLE.
- `mode` in 2: 0 = sweep all 36 class pairs; 1 = random classes; 2 and 3 = fixed classes.
- `cls_a`, `cls_b` in 3: class codes used in fixed mode.
- `count` in 16: number of pairs for modes 1–3. Latched at start.
- `opa`, `opb` out 32: operands.
- `op_valid` out 1, `op_ready` in 1: operand handshake.
- `exp_valid` out 1: the exp_* outputs are meaningful.
- `exp_inf`, `exp_ind`, `exp_qnan`, `exp_snan` out 1: expected combined flags.
- `exp_opa_nan`, `exp_opb_nan`, `exp_opa_00`, `exp_opb_00`, `exp_opa_inf`, `exp_opb_inf`, `exp_opa_dn`, `exp_opb_dn` out 1: expected per-operand flags.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- **Class codes:** 0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 QNAN, 5 SNAN. Codes 6 and 7 are treated as NORMAL.
- **Encoding per operand** (sign = LFSR bit 31):
  - ZERO: exponent 0, fraction 0.
  - DENORM: exponent 0, fraction = lfsr[22:0]; if that is 0, force fraction 1.
  - NORMAL: exponent = lfsr[30:23], with 0 mapped to 1 and 255 mapped to 254; fraction = lfsr[22:0].
  - INF: exponent 255, fraction 0.
  - QNAN: exponent 255, frac[22] = 1, frac[21:0] = lfsr.
  - SNAN: exponent 255, frac[22] = 0, frac[21:0] = lfsr; if that is 0, force frac[21:0] to 1.
- **Random mode class selection:** class = lfsr[2:0], with 6 mapped to 0 and 7 mapped to 1.
- **Sweep order:** a-major, pair index i = 6·cls_a + cls_b, i = 0..35. `count` is ignored.
- **LFSRs:** two 32-bit Galois LFSRs, polynomial 32'h8020_0003. Each advances exactly once per accepted pair (`op_valid & op_ready`).
- **Expected flags**, computed from the pair currently on `opa`/`opb`:
  - `exp_inf` = either operand is INF.
  - `exp_ind` = both operands are INF.
  - `exp_qnan` = either operand is QNAN.
  - `exp_snan` = either operand is SNAN.
  - `exp_opX_nan` = operand X is QNAN or SNAN.
  - `exp_opX_00` = operand X is ZERO.
  - `exp_opX_inf` = operand X is INF.
  - `exp_opX_dn` = operand X is ZERO or DENORM.
- **FSM:**
  - IDLE: on `start`, go to RUN and load the remaining-pair counter (36 in sweep mode, else `count`). If the load value is 0, go to DRAIN instead.
  - RUN: on each accepted pair, decrement the counter; on the last accepted pair, go to DRAIN.
  - DRAIN: wait 2 cycles, then go to IDLE, pulsing `done`.
- `start` outside IDLE is ignored.

## Timing
- **Reset:** all outputs 0, FSM in IDLE, LFSRs reloaded with their seeds, counters 0. An asserted `rst_n` mid-run aborts the run immediately with no `done` pulse.
- **Run start:** `start` sampled at edge k puts the first pair on the outputs with `op_valid` = 1 in the cycle after k.
- **Handshake:**
  - On an edge with `op_valid & op_ready`, the next pair is registered.
  - `opa`, `opb` and the LFSR state hold while `op_ready` = 0.
  - `op_valid` drops in the cycle after the last acceptance.
- **Expected-flag pipeline:**
  - Two register stages, advancing every cycle regardless of `op_ready`.
  - `exp_*` in cycle t+2 describe the `opa`/`opb` driven in cycle t.
  - `exp_valid` is `op_valid` delayed by 2 cycles. The `exp_*` outputs are 0 when `exp_valid` = 0.
- **`done`:** asserted in the cycle immediately after the last `exp_valid` = 1 cycle of the run. For count 0 it is asserted 3 cycles after the start edge. `busy` falls in the same cycle that `done` is asserted.

## Structure
- **Package `fpu_class_pkg`** holds:
  - class enum `fp_class_t`;
  - constants `EXP_MAX` = 8'hFF and `QNAN_BIT` = 22;
  - struct `exc_flags_t` containing the 12 expected flags;
  - function `encode_op(cls, lfsr)`;
  - function `class_flags(cls_a, cls_b)`.
- **Sub-module `fpu_class_lfsr`** (parameter SEED, enable input, 32-bit state output), instantiated twice.

## Test plan
- **Sweep:** mode 0, `op_ready` tied 1 → 36 pairs.
  - Pair 0: `opa[30:0]` = 0, `opb[30:0]` = 0, and 2 cycles later `exp_opa_00` = `exp_opa_dn` = 1.
  - Pair 21 (INF, INF): `exp_inf` = `exp_ind` = 1.
  - `done` pulses once.
- **Fixed classes:** mode 2, `cls_a` = 4, `cls_b` = 2, `count` = 4 → exactly 4 pairs, each with `opa[30:22]` = 9'h1FF, `exp_qnan` = 1, `exp_snan` = 0, `exp_opa_nan` = 1, `exp_opb_nan` = 0.
- **SNAN forcing:** fixed `cls_a` = 5 → every `opa` has `opa[22]` = 0 and `opa[21:0]` ≠ 0; `exp_snan` = 1.
- **Backpressure:** drop `op_ready` for 3 cycles mid-run → `opa`/`opb` stable for 3 cycles, pair sequence identical to an unstalled run with the same SEED.
- **Zero count:** `count` = 0, mode 1 → `op_valid` never high, `done` 3 cycles after the start edge.
- **Reset mid-run:** assert reset during RUN → all outputs 0 asynchronously. The next run with the same SEED reproduces the first pair exactly.

Source files
------------

// File: rtl/fpu_class_pkg.sv
// fpu_class_pkg
//   Shared definitions for the FPU special-operand generator:
//   - fp_class_t   : operand class codes (ZERO..SNAN)
//   - EXP_MAX      : all-ones single-precision exponent
//   - QNAN_BIT     : fraction bit that separates quiet from signalling NaN
//   - exc_flags_t  : the 12 flags the except stage is expected to raise
//   - to_class / random_class : map raw 3-bit codes onto fp_class_t
//   - encode_op    : build a 32-bit operand of a class from LFSR bits
//   - class_flags  : expected flags for an operand pair
//   - lfsr_step    : one advance of the 32-bit Galois LFSR
package fpu_class_pkg;

    typedef enum logic [2:0] {
        FC_ZERO   = 3'd0,
        FC_DENORM = 3'd1,
        FC_NORMAL = 3'd2,
        FC_INF    = 3'd3,
        FC_QNAN   = 3'd4,
        FC_SNAN   = 3'd5
    } fp_class_t;

    localparam logic [7:0]  EXP_MAX     = 8'hFF;
    localparam int          QNAN_BIT    = 22;
    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [15:0] SWEEP_PAIRS = 16'd36;

    typedef struct packed {
        logic inf;
        logic ind;
        logic qnan;
        logic snan;
        logic opa_nan;
        logic opb_nan;
        logic opa_00;
        logic opb_00;
        logic opa_inf;
        logic opb_inf;
        logic opa_dn;
        logic opb_dn;
    } exc_flags_t;

    // Codes 6 and 7 have no class of their own; they behave as NORMAL.
    function automatic fp_class_t to_class(input logic [2:0] code);
        if (code <= 3'd5) return fp_class_t'(code);
        else              return FC_NORMAL;
    endfunction

    // Random selection folds 6/7 onto ZERO/DENORM so the rare classes
    // show up a little more often than NORMAL.
    function automatic fp_class_t random_class(input logic [2:0] bits);
        case (bits)
            3'd6:    return FC_ZERO;
            3'd7:    return FC_DENORM;
            default: return fp_class_t'(bits);
        endcase
    endfunction

    function automatic logic [31:0] encode_op(input fp_class_t cls, input logic [31:0] lfsr);
        logic [7:0]  e;
        logic [22:0] f;
        e = '0;
        f = '0;
        case (cls)
            FC_ZERO: ;
            FC_DENORM: begin
                f = lfsr[22:0];
                if (f == '0) f = 23'd1;   // a zero fraction would be ZERO
            end
            FC_NORMAL: begin
                e = lfsr[30:23];
                if (e == 8'd0)         e = 8'd1;
                else if (e == EXP_MAX) e = 8'hFE;
                f = lfsr[22:0];
            end
            FC_INF: e = EXP_MAX;
            FC_QNAN: begin
                e = EXP_MAX;
                f[QNAN_BIT] = 1'b1;
                f[QNAN_BIT-1:0] = lfsr[QNAN_BIT-1:0];
            end
            FC_SNAN: begin
                e = EXP_MAX;
                f[QNAN_BIT-1:0] = lfsr[QNAN_BIT-1:0];
                // an all-zero payload with the quiet bit clear would be INF
                if (f[QNAN_BIT-1:0] == '0) f[QNAN_BIT-1:0] = 22'd1;
            end
            default: ;
        endcase
        return {lfsr[31], e, f};
    endfunction

    function automatic exc_flags_t class_flags(input fp_class_t cls_a, input fp_class_t cls_b);
        exc_flags_t fl;
        fl.opa_inf = (cls_a == FC_INF);
        fl.opb_inf = (cls_b == FC_INF);
        fl.opa_00  = (cls_a == FC_ZERO);
        fl.opb_00  = (cls_b == FC_ZERO);
        fl.opa_dn  = (cls_a == FC_ZERO) || (cls_a == FC_DENORM);
        fl.opb_dn  = (cls_b == FC_ZERO) || (cls_b == FC_DENORM);
        fl.opa_nan = (cls_a == FC_QNAN) || (cls_a == FC_SNAN);
        fl.opb_nan = (cls_b == FC_QNAN) || (cls_b == FC_SNAN);
        fl.inf     = fl.opa_inf | fl.opb_inf;
        fl.ind     = fl.opa_inf & fl.opb_inf;
        fl.qnan    = (cls_a == FC_QNAN) || (cls_b == FC_QNAN);
        fl.snan    = (cls_a == FC_SNAN) || (cls_b == FC_SNAN);
        return fl;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/fpu_class_lfsr.sv
// fpu_class_lfsr
//   32-bit Galois LFSR used as the payload source for one operand.
//   Ports:
//     clk, rst_n : clock / async active-low reset (reloads SEED)
//     en         : advance one step on the next rising edge
//     state      : current LFSR value
module fpu_class_lfsr
    import fpu_class_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2B3D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  state <= SEED;
        else if (en) state <= lfsr_step(state);
    end

endmodule

// File: rtl/fpu_special_opgen.sv
// fpu_special_opgen
//   Produces single-precision operand pairs of selected classes together
//   with the exception flags the except stage must raise two cycles later.
//   Ports:
//     clk, rst_n          : clock / async active-low reset
//     start               : run request (IDLE only)
//     mode                : 0 sweep 36 pairs, 1 random, 2/3 fixed classes
//     cls_a, cls_b        : class codes for fixed mode
//     count               : pairs per run for modes 1-3
//     opa, opb            : operands (0 when op_valid is low)
//     op_valid, op_ready  : operand handshake
//     exp_valid, exp_*    : expected flags, two cycles behind opa/opb
//     busy, done          : run active / end-of-run pulse
//
//   Handshake: a pair transfers on every rising edge where op_valid and
//   op_ready are both 1; op_valid never drops before that transfer and
//   opa/opb stay unchanged while op_ready is 0.
module fpu_special_opgen
    import fpu_class_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2B3D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [2:0]  cls_a,
    input  logic [2:0]  cls_b,
    input  logic [15:0] count,
    output logic [31:0] opa,
    output logic [31:0] opb,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        exp_valid,
    output logic        exp_inf,
    output logic        exp_ind,
    output logic        exp_qnan,
    output logic        exp_snan,
    output logic        exp_opa_nan,
    output logic        exp_opb_nan,
    output logic        exp_opa_00,
    output logic        exp_opb_00,
    output logic        exp_opa_inf,
    output logic        exp_opb_inf,
    output logic        exp_opa_dn,
    output logic        exp_opb_dn,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [15:0] rem, rem_d;
    logic        dcnt, dcnt_d;
    logic        done_q, done_d;
    logic [1:0]  mode_q, mode_d;
    fp_class_t   fix_a, fix_a_d, fix_b, fix_b_d;
    logic [2:0]  sw_a, sw_a_d, sw_b, sw_b_d;

    logic [31:0] lfsr_a, lfsr_b;
    fp_class_t   cur_a, cur_b;
    logic        accept;

    logic        s1_valid, s2_valid;
    exc_flags_t  s1_flags, s2_flags;

    assign op_valid = (state == ST_RUN);
    assign accept   = op_valid & op_ready;

    fpu_class_lfsr #(.SEED(SEED)) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .state (lfsr_a)
    );

    fpu_class_lfsr #(.SEED(~SEED)) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .state (lfsr_b)
    );

    // Class of the pair currently presented.
    always_comb begin
        cur_a = fix_a;
        cur_b = fix_b;
        case (mode_q)
            2'd0: begin
                cur_a = to_class(sw_a);
                cur_b = to_class(sw_b);
            end
            2'd1: begin
                cur_a = random_class(lfsr_a[2:0]);
                cur_b = random_class(lfsr_b[2:0]);
            end
            default: ;
        endcase
    end

    // Operands are pure functions of registered state, so they hold
    // automatically while the LFSRs are not advancing.
    assign opa = op_valid ? encode_op(cur_a, lfsr_a) : 32'h0;
    assign opb = op_valid ? encode_op(cur_b, lfsr_b) : 32'h0;

    always_comb begin
        state_d = state;
        rem_d   = rem;
        dcnt_d  = dcnt;
        done_d  = 1'b0;
        mode_d  = mode_q;
        fix_a_d = fix_a;
        fix_b_d = fix_b;
        sw_a_d  = sw_a;
        sw_b_d  = sw_b;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    fix_a_d = to_class(cls_a);
                    fix_b_d = to_class(cls_b);
                    sw_a_d  = 3'd0;
                    sw_b_d  = 3'd0;
                    dcnt_d  = 1'b0;
                    rem_d   = (mode == 2'd0) ? SWEEP_PAIRS : count;
                    state_d = (rem_d == 16'd0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rem_d = rem - 16'd1;
                    if (sw_b == 3'd5) begin
                        sw_b_d = 3'd0;
                        sw_a_d = sw_a + 3'd1;
                    end else begin
                        sw_b_d = sw_b + 3'd1;
                    end
                    if (rem == 16'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // two cycles lets the last pair's flags leave the pipeline
                if (dcnt) begin
                    state_d = ST_IDLE;
                    dcnt_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rem    <= '0;
            dcnt   <= 1'b0;
            done_q <= 1'b0;
            mode_q <= '0;
            fix_a  <= FC_ZERO;
            fix_b  <= FC_ZERO;
            sw_a   <= '0;
            sw_b   <= '0;
        end else begin
            state  <= state_d;
            rem    <= rem_d;
            dcnt   <= dcnt_d;
            done_q <= done_d;
            mode_q <= mode_d;
            fix_a  <= fix_a_d;
            fix_b  <= fix_b_d;
            sw_a   <= sw_a_d;
            sw_b   <= sw_b_d;
        end
    end

    // Flag pipeline runs every cycle; it tracks the bus, not transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_flags <= '0;
            s2_valid <= 1'b0;
            s2_flags <= '0;
        end else begin
            s1_valid <= op_valid;
            s1_flags <= op_valid ? class_flags(cur_a, cur_b) : '0;
            s2_valid <= s1_valid;
            s2_flags <= s1_flags;
        end
    end

    assign exp_valid   = s2_valid;
    assign exp_inf     = s2_flags.inf;
    assign exp_ind     = s2_flags.ind;
    assign exp_qnan    = s2_flags.qnan;
    assign exp_snan    = s2_flags.snan;
    assign exp_opa_nan = s2_flags.opa_nan;
    assign exp_opb_nan = s2_flags.opb_nan;
    assign exp_opa_00  = s2_flags.opa_00;
    assign exp_opb_00  = s2_flags.opb_00;
    assign exp_opa_inf = s2_flags.opa_inf;
    assign exp_opb_inf = s2_flags.opb_inf;
    assign exp_opa_dn  = s2_flags.opa_dn;
    assign exp_opb_dn  = s2_flags.opb_dn;

    assign busy = (state != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_fpu_special_opgen.sv
// tb_fpu_special_opgen
//   Directed bench for fpu_special_opgen: sweep, fixed classes, SNAN
//   payload forcing, zero count, backpressure and mid-run reset.
module tb_fpu_special_opgen;

    localparam logic [31:0] SEED = 32'hACE1_2B3D;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  cls_a, cls_b;
    logic [15:0] count;
    logic [31:0] opa, opb;
    logic        op_valid, op_ready;
    logic        exp_valid, exp_inf, exp_ind, exp_qnan, exp_snan;
    logic        exp_opa_nan, exp_opb_nan, exp_opa_00, exp_opb_00;
    logic        exp_opa_inf, exp_opb_inf, exp_opa_dn, exp_opb_dn;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    // reference LFSR states for the pair currently expected on the bus
    logic [31:0] la, lb;
    logic [12:0] exp_q[$];

    fpu_special_opgen #(.SEED(SEED)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .cls_a       (cls_a),
        .cls_b       (cls_b),
        .count       (count),
        .opa         (opa),
        .opb         (opb),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .exp_valid   (exp_valid),
        .exp_inf     (exp_inf),
        .exp_ind     (exp_ind),
        .exp_qnan    (exp_qnan),
        .exp_snan    (exp_snan),
        .exp_opa_nan (exp_opa_nan),
        .exp_opb_nan (exp_opb_nan),
        .exp_opa_00  (exp_opa_00),
        .exp_opb_00  (exp_opb_00),
        .exp_opa_inf (exp_opa_inf),
        .exp_opb_inf (exp_opb_inf),
        .exp_opa_dn  (exp_opa_dn),
        .exp_opb_dn  (exp_opb_dn),
        .busy        (busy),
        .done        (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model helpers
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic int m_rnd(input logic [2:0] b);
        if (b == 3'd6) return 0;
        if (b == 3'd7) return 1;
        return int'(b);
    endfunction

    function automatic int m_fix(input logic [2:0] c);
        return (c > 3'd5) ? 2 : int'(c);
    endfunction

    function automatic logic [31:0] m_enc(input int c, input logic [31:0] r);
        logic [7:0]  e;
        logic [22:0] f;
        case (c)
            0: begin e = 8'd0;  f = 23'd0; end
            1: begin e = 8'd0;  f = (r[22:0] == 23'd0) ? 23'd1 : r[22:0]; end
            3: begin e = 8'hFF; f = 23'd0; end
            4: begin e = 8'hFF; f = {1'b1, r[21:0]}; end
            5: begin e = 8'hFF; f = {1'b0, (r[21:0] == 22'd0) ? 22'd1 : r[21:0]}; end
            default: begin
                e = r[30:23];
                if (e == 8'd0) e = 8'd1;
                if (e == 8'd255) e = 8'd254;
                f = r[22:0];
            end
        endcase
        return {r[31], e, f};
    endfunction

    // {inf, ind, qnan, snan, a_nan, b_nan, a_00, b_00, a_inf, b_inf, a_dn, b_dn}
    function automatic logic [11:0] m_flags(input int a, input int b);
        return {(a == 3) || (b == 3), (a == 3) && (b == 3),
                (a == 4) || (b == 4), (a == 5) || (b == 5),
                (a == 4) || (a == 5), (b == 4) || (b == 5),
                a == 0, b == 0, a == 3, b == 3,
                a <= 1, b <= 1};
    endfunction

    function automatic logic [11:0] dut_flags();
        return {exp_inf, exp_ind, exp_qnan, exp_snan, exp_opa_nan, exp_opb_nan,
                exp_opa_00, exp_opb_00, exp_opa_inf, exp_opb_inf, exp_opa_dn, exp_opb_dn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ops"}, opa | opb, 32'h0);
        chk({tag, "_ctl"}, {19'd0, op_valid, exp_valid, busy, done, dut_flags()}, 32'h0);
    endtask

    // reset pulse; called at a negedge, returns at a negedge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        la = SEED;
        lb = ~SEED;
    endtask

    // One run from a negedge. stall_at: cycle where op_ready drops for 3
    // cycles (-1 none). abort_at: cycle where reset is asserted (-1 none).
    task automatic do_run(input logic [1:0] m, input logic [2:0] ca, input logic [2:0] cb,
                          input logic [15:0] cnt, input int stall_at, input int abort_at);
        int npairs, pidx, cyc, done_at, stall_left, xa, xb, c21;
        logic vld, finished, aborted;
        logic [12:0] old_e;
        npairs     = (m == 2'd0) ? 36 : int'(cnt);
        pidx       = 0;
        done_at    = (npairs == 0) ? 3 : 100000;
        stall_left = 0;
        c21        = -10;
        finished   = 1'b0;
        aborted    = 1'b0;
        exp_q.delete();
        exp_q.push_back(13'd0);
        exp_q.push_back(13'd0);
        mode = m; cls_a = ca; cls_b = cb; count = cnt;
        op_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (m == 2'd0) begin
                xa = pidx / 6; xb = pidx % 6;
            end else if (m == 2'd1) begin
                xa = m_rnd(la[2:0]); xb = m_rnd(lb[2:0]);
            end else begin
                xa = m_fix(ca); xb = m_fix(cb);
            end
            vld = (pidx < npairs);
            chk("op_valid", {31'd0, op_valid}, {31'd0, vld});
            chk("busy", {31'd0, busy}, {31'd0, cyc < done_at});
            chk("done", {31'd0, done}, {31'd0, cyc == done_at});
            chk("opa", opa, vld ? m_enc(xa, la) : 32'h0);
            chk("opb", opb, vld ? m_enc(xb, lb) : 32'h0);
            old_e = exp_q.pop_front();
            chk("exp_flags", {19'd0, exp_valid, dut_flags()}, {19'd0, old_e});
            exp_q.push_back(vld ? {1'b1, m_flags(xa, xb)} : 13'd0);
            // hand-derived spot checks
            if (m == 2'd0 && cyc == 1)
                chk("sweep0_mag", {1'b0, opa[30:0]} | {1'b0, opb[30:0]}, 32'h0);
            if (m == 2'd0 && cyc == 3)
                chk("sweep0_flags", {30'd0, exp_opa_00, exp_opa_dn}, 32'd3);
            if (m == 2'd0 && vld && pidx == 21) c21 = cyc;
            if (cyc == c21 + 2)
                chk("sweep21_ind", {30'd0, exp_inf, exp_ind}, 32'd3);
            if (vld && m >= 2'd2 && ca == 3'd4)
                chk("qnan_exp_bits", {23'd0, opa[30:22]}, 32'h1FF);
            if (vld && m >= 2'd2 && ca == 3'd5)
                chk("snan_payload", {30'd0, opa[22], opa[21:0] != 22'd0}, 32'd1);
            if (exp_valid && m >= 2'd2 && ca == 3'd4)
                chk("qnan_flags", {27'd0, exp_qnan, exp_snan, exp_opa_nan, exp_opb_nan, 1'b0},
                    {27'd0, 1'b1, cb == 3'd5, 1'b1, cb == 3'd4 || cb == 3'd5, 1'b0});
            if (exp_valid && m >= 2'd2 && ca == 3'd5)
                chk("snan_flag", {31'd0, exp_snan}, 32'd1);
            if (cyc == done_at) begin
                finished = 1'b1;
                break;
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("abort");
                la = SEED;
                lb = ~SEED;
                @(negedge clk);
                chk("abort_no_done", {31'd0, done}, 32'd0);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (cyc == stall_at) stall_left = 3;
            op_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (vld && op_ready) begin
                la = m_step(la);
                lb = m_step(lb);
                pidx++;
                if (pidx == npairs) done_at = cyc + 3;
            end
            @(negedge clk);
        end
        if (!aborted) chk("run_end", {31'd0, finished}, 32'd1);
        op_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; cls_a = 3'd0; cls_b = 3'd0;
        count = 16'd0; op_ready = 1'b1;
        la = SEED; lb = ~SEED;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        do_run(2'd0, 3'd0, 3'd0, 16'd0, -1, -1);   // sweep, count ignored
        do_run(2'd2, 3'd4, 3'd2, 16'd4, -1, -1);   // QNAN x NORMAL
        do_run(2'd3, 3'd5, 3'd1, 16'd3, -1, -1);   // SNAN x DENORM
        do_run(2'd2, 3'd7, 3'd3, 16'd2, -1, -1);   // code 7 acts as NORMAL
        do_run(2'd1, 3'd0, 3'd0, 16'd0, -1, -1);   // zero count

        do_reset();
        do_run(2'd1, 3'd0, 3'd0, 16'd6, -1, -1);   // unstalled reference
        do_reset();
        do_run(2'd1, 3'd0, 3'd0, 16'd6, 3, -1);    // same seed, 3-cycle stall

        do_reset();
        do_run(2'd1, 3'd0, 3'd0, 16'd8, -1, 4);    // reset mid-run
        do_run(2'd1, 3'd0, 3'd0, 16'd3, -1, -1);   // reproduces from seed

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
